if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined CPU. It owns the program counter, drives the byte address into the combinational big-endian instruction memory, and captures the returned word into the IF/ID pipeline register. It also handles hazard stalls, branch/jump redirects, halt detection, and a retired-fetch counter.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ROM_BYTES, 512, instruction memory size in bytes; used only by the address check.
- HALT_OPCODE, 6'h3F, value of ins_data[31:26] that marks a halt instruction.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit hold request for the PC and IF/ID.
- redirect_valid  in  1  taken branch/jump from a later stage.
- redirect_pc  in  32  redirect target.
- ins_addr  out  32  byte address to the instruction memory; equals pc combinationally.
- ins_data  in  32  instruction word from memory, valid in the same cycle.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  32  latched instruction; NOP (32'h0) when invalid.
- if_id_pc  out  32  address of the latched instruction.
- if_id_pc4  out  32  if_id_pc + 4.
- halted  out  1  fetch is frozen after a halt or fault.
- fetch_fault  out  1  sticky address fault; tied 0 when the check is compiled out.
- fetch_count  out  32  count of valid instructions latched into IF/ID.

## Operation
- States:
  - RUN: normal fetch.
  - HALT: fetch frozen.
- Per-edge priority: rst > redirect_valid > fault (when compiled in) > state HALT > stall > normal.
- rst:
  - pc=RESET_PC, state=RUN.
  - IF/ID cleared: valid=0, instr=0, pc=0, pc4=0.
  - fetch_count=0, fetch_fault=0.
- redirect_valid (in either state, stall ignored):
  - pc=redirect_pc, state=RUN.
  - IF/ID flushed to NOP with valid=0.
  - fetch_count unchanged.
- HALT, no redirect: pc and state hold; IF/ID loads NOP with valid=0.
- RUN with stall: pc, IF/ID and fetch_count all hold.
- RUN, normal edge:
  - IF/ID loads {valid=1, instr=ins_data, pc, pc+4}.
  - fetch_count increments by 1.
  - If ins_data[31:26]==HALT_OPCODE: state=HALT and pc holds. Otherwise pc=pc+4.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. fetch_count wraps silently.
- halted = (state==HALT).
- A halt instruction that is fetched but then flushed by a redirect does not halt; the redirect wins on the same edge.

## Timing
- Fetch latency: one cycle. An address presented in cycle n appears on if_id_* after edge n.
- Redirect-to-fetch: redirect_pc is on ins_addr in the cycle after the redirect edge. There is exactly one bubble in IF/ID.
- All outputs are registered except ins_addr, which follows pc combinationally.
- Reset values: ins_addr=RESET_PC; all other outputs 0.
- Reset asserted mid-stall or in HALT overrides everything on that edge.

## Configuration
- IF_ADDR_CHECK_EN:
  - Defined: a RUN edge without redirect where pc[1:0]!=0 or pc > ROM_BYTES-4 is a fault. On that edge:
    - fetch_fault=1 (sticky until rst).
    - state=HALT.
    - IF/ID loads NOP with valid=0.
    - fetch_count does not increment.
    - A later redirect clears HALT but not fetch_fault.
  - Undefined: no check; fetch_fault is constant 0 and out-of-range addresses are fetched as-is.

## Structure
- Shared package if_pkg holds:
  - NOP (32'h0000_0000).
  - Default HALT_OPCODE.
  - State enum {RUN, HALT}.
- One natural sub-module, pc_reg: the PC register plus next-PC mux (redirect/hold/increment). The IF/ID register, state machine and counter stay in if_stage.

## Test plan
- Reset sequence: rst high for 2 cycles, then low -> ins_addr=0 and if_id_valid=0 in the first cycle. After edge 1: if_id_pc=0, if_id_pc4=4, ins_addr=4, fetch_count=1.
- Stall: stall=1 for 3 cycles while pc=8 -> ins_addr stays 8 and IF/ID keeps pc=4 and its instruction. fetch_count is unchanged. Pc resumes to 12 after release.
- Redirect during stall: stall=1, redirect_valid=1, redirect_pc=0x40 -> next ins_addr=0x40, if_id_valid=0, if_id_instr=0.
- Halt: word at 0x10 is 32'hFC00_0000 -> if_id_instr=FC00_0000 with valid=1, halted=1, ins_addr stays 0x10. The next cycles show if_id_valid=0.
- Exit HALT: redirect_pc=0x20 while halted -> halted=0, ins_addr=0x20. After the next edge: if_id_pc=0x20, valid=1.
- With IF_ADDR_CHECK_EN defined: redirect_pc=0x22 -> after the next edge fetch_fault=1, halted=1, if_id_valid=0, fetch_count unchanged. A later redirect to 0x0 clears halted; fetch_fault stays 1.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP                  : bubble instruction word placed in IF/ID when it is invalid.
//   HALT_OPCODE_DEFAULT  : default value of instr[31:26] that marks a halt.
//   if_state_e           : fetch state machine states (RUN, HALT).
//   pc_plus4()           : modulo-2^32 sequential PC increment.
package if_pkg;

  localparam logic [31:0] NOP                 = 32'h0000_0000;
  localparam logic [5:0]  HALT_OPCODE_DEFAULT = 6'h3F;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } if_state_e;

  // Wraps 32'hFFFF_FFFC to 0 by plain 32-bit truncation.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its next-PC mux.
// Priority on each rising edge: reset > redirect > hold > increment by 4.
// Ports:
//   i_clk            : clock
//   i_rst            : synchronous active-high reset, loads RESET_PC
//   i_redirect_valid : load i_redirect_pc (overrides hold)
//   i_redirect_pc    : redirect target
//   i_hold           : keep the current PC
//   o_pc             : current PC (registered)
module pc_reg
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_hold,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;

  always_comb begin
    w_pc_next = pc_plus4(r_pc);
    if (i_redirect_valid) begin
      w_pc_next = i_redirect_pc;
    end else if (i_hold) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational big-endian
// instruction memory, captures the returned word into the IF/ID register, and
// handles stalls, redirects, halt detection and a retired-fetch counter.
// Optional feature macro: IF_ADDR_CHECK_EN (misaligned / out-of-ROM fetch fault).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   stall               : hold PC, IF/ID and counter
//   redirect_valid/_pc  : taken branch/jump target from a later stage
//   ins_addr            : byte address to instruction memory (= pc, combinational)
//   ins_data            : instruction word returned in the same cycle
//   if_id_valid/instr   : IF/ID valid flag and instruction (NOP when invalid)
//   if_id_pc/pc4        : address of latched instruction and that address + 4
//   halted              : fetch frozen after a halt instruction or fault
//   fetch_fault         : sticky address fault (0 when the check is compiled out)
//   fetch_count         : number of valid instructions latched into IF/ID
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ROM_BYTES   = 512,
  parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ins_addr,
  input  logic [31:0] ins_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        halted,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  if_state_e   r_state;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc4;
  logic [31:0] r_count;

  logic [31:0] w_pc;
  logic        w_fault;
  logic        w_is_halt;
  logic        w_pc_hold;

  assign w_is_halt = (ins_data[31:26] == HALT_OPCODE);

`ifdef IF_ADDR_CHECK_EN
  localparam logic [31:0] ROM_LAST = 32'(ROM_BYTES - 4);

  logic r_fetch_fault;

  // Only an actual fetch attempt in RUN can fault; a redirect on the same
  // edge replaces the offending PC before it is used.
  assign w_fault = (r_state == RUN) && !redirect_valid &&
                   ((w_pc[1:0] != 2'b00) || (w_pc > ROM_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_fault <= 1'b0;
    end else if (w_fault) begin
      r_fetch_fault <= 1'b1;
    end
  end

  assign fetch_fault = r_fetch_fault;
`else
  assign w_fault     = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // The PC advances only on a normal RUN fetch of a non-halt instruction.
  assign w_pc_hold = w_fault || (r_state == HALT) || stall || w_is_halt;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc),
    .i_hold          (w_pc_hold),
    .o_pc            (w_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_valid <= 1'b0;
      r_instr <= NOP;
      r_pc    <= 32'h0;
      r_pc4   <= 32'h0;
      r_count <= 32'h0;
    end else if (redirect_valid) begin
      // Flush wins over a halt fetched on the same edge.
      r_state <= RUN;
      r_valid <= 1'b0;
      r_instr <= NOP;
    end else if (w_fault) begin
      r_state <= HALT;
      r_valid <= 1'b0;
      r_instr <= NOP;
    end else if (r_state == HALT) begin
      r_valid <= 1'b0;
      r_instr <= NOP;
    end else if (!stall) begin
      r_valid <= 1'b1;
      r_instr <= ins_data;
      r_pc    <= w_pc;
      r_pc4   <= pc_plus4(w_pc);
      r_count <= r_count + 32'd1;
      if (w_is_halt) begin
        r_state <= HALT;
      end
    end
  end

  assign ins_addr    = w_pc;
  assign if_id_valid = r_valid;
  assign if_id_instr = r_instr;
  assign if_id_pc    = r_pc;
  assign if_id_pc4   = r_pc4;
  assign halted      = (r_state == HALT);
  assign fetch_count = r_count;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] ins_addr;
  logic [31:0] ins_data;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        halted;
  logic        fetch_fault;
  logic [31:0] fetch_count;

`ifdef IF_ADDR_CHECK_EN
  localparam bit FaultEn = 1'b1;
`else
  localparam bit FaultEn = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ins_addr      (ins_addr),
    .ins_data      (ins_data),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc4     (if_id_pc4),
    .halted        (halted),
    .fetch_fault   (fetch_fault),
    .fetch_count   (fetch_count)
  );

  // Byte-addressed big-endian ROM; bytes outside 512 read as zero.
  logic [7:0] rom [512];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (a < 32'd512) return rom[a[8:0]];
    return 8'h00;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return {rd_byte(a), rd_byte(a + 32'd1), rd_byte(a + 32'd2), rd_byte(a + 32'd3)};
  endfunction

  assign ins_data = mem_read(ins_addr);

  // Behavioural model of the fetch stage, stepped once per clock edge.
  logic [31:0] m_pc;
  logic        m_halt;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ifpc;
  logic [31:0] m_count;
  logic        m_fault;
  logic [31:0] m_word;

  assign m_word = mem_read(m_pc);

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 32'h0; m_halt <= 1'b0; m_valid <= 1'b0; m_instr <= 32'h0;
      m_ifpc <= 32'h0; m_count <= 32'h0; m_fault <= 1'b0;
    end else if (redirect_valid) begin
      m_pc <= redirect_pc; m_halt <= 1'b0; m_valid <= 1'b0; m_instr <= 32'h0;
    end else if (FaultEn && !m_halt && ((m_pc % 4) != 0 || m_pc > 32'd508)) begin
      m_fault <= 1'b1; m_halt <= 1'b1; m_valid <= 1'b0; m_instr <= 32'h0;
    end else if (m_halt) begin
      m_valid <= 1'b0; m_instr <= 32'h0;
    end else if (!stall) begin
      m_valid <= 1'b1; m_instr <= m_word; m_ifpc <= m_pc; m_count <= m_count + 1;
      if (m_word[31:26] == 6'h3F) m_halt <= 1'b1;
      else m_pc <= m_pc + 32'd4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp ins_addr", ins_addr, m_pc);
      check("cmp valid", 32'(if_id_valid), 32'(m_valid));
      check("cmp instr", if_id_instr, m_instr);
      check("cmp halted", 32'(halted), 32'(m_halt));
      check("cmp fault", 32'(fetch_fault), 32'(m_fault));
      check("cmp count", fetch_count, m_count);
      if (m_valid) begin
        check("cmp if_id_pc", if_id_pc, m_ifpc);
        check("cmp if_id_pc4", if_id_pc4, m_ifpc + 32'd4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    for (int a = 0; a < 512; a += 4) begin
      w = (a == 16) ? 32'hFC00_0000 : (32'h0400_0000 | 32'(a));
      rom[a]     = w[31:24];
      rom[a + 1] = w[23:16];
      rom[a + 2] = w[15:8];
      rom[a + 3] = w[7:0];
    end
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    tick();
    chk_en = 1'b1;
    tick();
    check("reset ins_addr", ins_addr, 32'h0);
    check("reset valid", 32'(if_id_valid), 32'h0);
    check("reset count", fetch_count, 32'h0);
    rst = 1'b0;

    tick();
    check("edge1 if_id_pc", if_id_pc, 32'h0);
    check("edge1 if_id_pc4", if_id_pc4, 32'h4);
    check("edge1 ins_addr", ins_addr, 32'h4);
    check("edge1 count", fetch_count, 32'h1);

    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall ins_addr", ins_addr, 32'h8);
      check("stall if_id_pc", if_id_pc, 32'h4);
      check("stall instr", if_id_instr, 32'h0400_0004);
      check("stall count", fetch_count, 32'h2);
    end
    stall = 1'b0;
    tick();
    check("release if_id_pc", if_id_pc, 32'h8);
    check("release ins_addr", ins_addr, 32'hC);

    stall = 1'b1;
    redirect_to(32'h40);
    stall = 1'b0;
    check("redir-stall ins_addr", ins_addr, 32'h40);
    check("redir-stall valid", 32'(if_id_valid), 32'h0);
    check("redir-stall instr", if_id_instr, 32'h0);
    check("redir-stall count", fetch_count, 32'h3);
    tick();
    tick();
    check("after-redir count", fetch_count, 32'h5);

    redirect_to(32'h10);
    tick();
    check("halt instr", if_id_instr, 32'hFC00_0000);
    check("halt valid", 32'(if_id_valid), 32'h1);
    check("halt halted", 32'(halted), 32'h1);
    check("halt ins_addr", ins_addr, 32'h10);
    tick();
    check("halted bubble", 32'(if_id_valid), 32'h0);
    check("halted count", fetch_count, 32'h6);
    tick();

    redirect_to(32'h20);
    check("exit halted", 32'(halted), 32'h0);
    check("exit ins_addr", ins_addr, 32'h20);
    tick();
    check("exit if_id_pc", if_id_pc, 32'h20);
    check("exit valid", 32'(if_id_valid), 32'h1);

    redirect_to(32'hC);
    tick();
    check("pre-flush ins_addr", ins_addr, 32'h10);
    redirect_to(32'h30);
    check("flushed halt halted", 32'(halted), 32'h0);
    check("flushed halt ins_addr", ins_addr, 32'h30);
    check("flushed halt count", fetch_count, 32'h8);

`ifdef IF_ADDR_CHECK_EN
    redirect_to(32'h22);
    tick();
    check("fault flag", 32'(fetch_fault), 32'h1);
    check("fault halted", 32'(halted), 32'h1);
    check("fault valid", 32'(if_id_valid), 32'h0);
    check("fault count", fetch_count, 32'h8);
    tick();
    redirect_to(32'h0);
    check("fault-exit halted", 32'(halted), 32'h0);
    check("fault sticky", 32'(fetch_fault), 32'h1);
    tick();
    check("fault-exit count", fetch_count, 32'h9);
`else
    redirect_to(32'hFFFF_FFFC);
    tick();
    check("wrap if_id_pc", if_id_pc, 32'hFFFF_FFFC);
    check("wrap if_id_pc4", if_id_pc4, 32'h0);
    check("wrap ins_addr", ins_addr, 32'h0);
    check("wrap count", fetch_count, 32'h9);
    check("no fault", 32'(fetch_fault), 32'h0);
    tick();
`endif

    redirect_to(32'h10);
    tick();
    check("pre-reset halted", 32'(halted), 32'h1);
    stall = 1'b1;
    rst   = 1'b1;
    tick();
    check("rst-halt ins_addr", ins_addr, 32'h0);
    check("rst-halt halted", 32'(halted), 32'h0);
    check("rst-halt count", fetch_count, 32'h0);
    check("rst-halt fault", 32'(fetch_fault), 32'h0);
    check("rst-halt pc4", if_id_pc4, 32'h0);
    rst   = 1'b0;
    stall = 1'b0;
    tick();
    check("post-reset count", fetch_count, 32'h1);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
